// File: rtl/kbd_source_arbiter.sv
// Merges PS/2 typed keys and a paced host paste stream into the Apple-1 keyboard register.
// Typed keys go through a typeahead FIFO; paste chars are admitted only when everything is idle.
module kbd_source_arbiter #(
    parameter int FIFO_DEPTH = 8,
    parameter int PASTE_GAP  = 2500,
    parameter int CR_GAP     = 25000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_valid,
    input  logic [6:0] ps2_ascii,
    input  logic       paste_valid,
    input  logic [6:0] paste_ascii,
    output logic       paste_ready,
    input  logic       cs,
    input  logic       address,
    output logic [7:0] dout,
    output logic       overflow
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int GAP_MAX = (PASTE_GAP > CR_GAP) ? PASTE_GAP : CR_GAP;
    localparam int GAP_W   = (GAP_MAX > 0) ? $clog2(GAP_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [GAP_W-1:0] GAP_PASTE = GAP_W'(PASTE_GAP);
    localparam logic [GAP_W-1:0] GAP_CR    = GAP_W'(CR_GAP);

    logic [6:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [6:0]       key;
    logic             key_rdy;
    logic [GAP_W-1:0] gap;

    logic       fifo_empty;
    logic       fifo_full;
    logic       drop;
    logic       paste_fire;
    logic       push;
    logic       pop;
    logic [6:0] push_data;
    logic       data_read;
    logic       status_read;

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == FULL_CNT);
    assign drop        = ps2_valid && fifo_full;

    // A typed strobe always owns the cycle, so paste is only offered when the path is idle.
    assign paste_ready = !rst && (gap == '0) && fifo_empty && !key_rdy && !ps2_valid;
    assign paste_fire  = paste_valid && paste_ready;

    assign push      = (ps2_valid && !fifo_full) || paste_fire;
    assign push_data = ps2_valid ? ps2_ascii : paste_ascii;
    // Pop only into an empty holding register, so a data read that clears key_rdy
    // delays the next load by one cycle and keys are never merged.
    assign pop       = !key_rdy && !fifo_empty;

    assign data_read   = cs && !address;
    assign status_read = cs && address;

    // NOTE: the storage array has no reset; count and the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: every register below uses <= so all decisions in a cycle see the pre-edge state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key     <= '0;
            key_rdy <= 1'b0;
        end else if (pop) begin
            key     <= mem[rd_ptr];
            key_rdy <= 1'b1;
        end else if (data_read) begin
            key_rdy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap <= '0;
        end else if (paste_fire) begin
            gap <= (paste_ascii == 7'h0D) ? GAP_CR : GAP_PASTE;
        end else if (gap != '0) begin
            gap <= gap - 1'b1;
        end
    end

    // A drop on the same edge as a status read keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (status_read) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= 8'h00;
        end else if (data_read) begin
            dout <= {1'b1, key};
        end else if (status_read) begin
            dout <= {key_rdy, overflow, 6'b0};
        end
    end

endmodule

// File: tb/tb_kbd_source_arbiter.sv
// Bench for kbd_source_arbiter: queue-based reference model, read scoreboard with a
// separate monitor, directed scenarios followed by randomized traffic.
module tb_kbd_source_arbiter;

    localparam int DEPTH = 8;
    localparam int PG    = 4;
    localparam int CG    = 10;

    logic       clk;
    logic       rst;
    logic       ps2_valid;
    logic [6:0] ps2_ascii;
    logic       paste_valid;
    logic [6:0] paste_ascii;
    logic       paste_ready;
    logic       cs;
    logic       address;
    logic [7:0] dout;
    logic       overflow;

    kbd_source_arbiter #(
        .FIFO_DEPTH(DEPTH),
        .PASTE_GAP (PG),
        .CR_GAP    (CG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_valid  (ps2_valid),
        .ps2_ascii  (ps2_ascii),
        .paste_valid(paste_valid),
        .paste_ascii(paste_ascii),
        .paste_ready(paste_ready),
        .cs         (cs),
        .address    (address),
        .dout       (dout),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    string cur_test = "init";

    // Reference model: accepted characters as a queue plus the holding register.
    logic [6:0] m_fifo[$];
    logic [6:0] m_key;
    logic       m_rdy;
    logic       m_ovf;
    int         m_gap;

    logic [7:0] exp_q[$];
    logic       last_pr;
    logic       last_fire;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", cur_test, name, act, exp, $time);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int min);
        n_checks++;
        if (act < min) begin
            n_fail++;
            $display("FAIL %s/%s: got %0d expected at least %0d", cur_test, name, act, min);
        end
    endtask

    task automatic model_step(input logic r, input logic pv, input logic [6:0] pa,
                              input logic qv, input logic [6:0] qa,
                              input logic c, input logic a, input logic exp_pr, input int spec);
        logic       drop;
        logic [7:0] rd_val;
        if (r) begin
            m_fifo.delete();
            m_key = '0;
            m_rdy = 1'b0;
            m_ovf = 1'b0;
            m_gap = 0;
            return;
        end
        if (c) begin
            rd_val = a ? {m_rdy, m_ovf, 6'b0} : {1'b1, m_key};
            exp_q.push_back(spec >= 0 ? spec[7:0] : rd_val);
        end
        drop = pv && (m_fifo.size() == DEPTH);
        if (!m_rdy && m_fifo.size() > 0) begin
            m_key = m_fifo.pop_front();
            m_rdy = 1'b1;
        end else if (c && !a) begin
            m_rdy = 1'b0;
        end
        if (pv && !drop)         m_fifo.push_back(pa);
        else if (qv && exp_pr)   m_fifo.push_back(qa);
        if (drop)                m_ovf = 1'b1;
        else if (c && a)         m_ovf = 1'b0;
        if (qv && exp_pr)        m_gap = (qa == 7'h0D) ? CG : PG;
        else if (m_gap > 0)      m_gap--;
    endtask

    // One clock cycle of stimulus; spec >= 0 forces the expected read value.
    task automatic cyc(input logic r, input logic pv, input logic [6:0] pa,
                       input logic qv, input logic [6:0] qa,
                       input logic c, input logic a, input int spec = -1);
        logic exp_pr;
        @(negedge clk);
        rst         = r;
        ps2_valid   = pv;
        ps2_ascii   = pa;
        paste_valid = qv;
        paste_ascii = qa;
        cs          = c;
        address     = a;
        #1;
        exp_pr = !r && (m_gap == 0) && (m_fifo.size() == 0) && !m_rdy && !pv;
        check("paste_ready", {31'b0, paste_ready}, {31'b0, exp_pr});
        last_pr   = paste_ready;
        last_fire = qv && paste_ready;
        model_step(r, pv, pa, qv, qa, c, a, exp_pr, spec);
    endtask

    task automatic idle();
        cyc(0, 0, 7'h00, 0, 7'h00, 0, 0);
    endtask

    // Monitor: every CPU read edge must be matched by a queued expectation.
    initial begin
        logic       sampled;
        logic [7:0] e;
        forever begin
            @(posedge clk);
            sampled = cs && !rst;
            #1;
            if (sampled) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s/scoreboard: read with no expectation, dout=%0h", cur_test, dout);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", {24'b0, dout}, {24'b0, e});
                end
            end
        end
    end

    task automatic paste_char(input logic [6:0] ch, input int gap_min, input int rd_exp);
        int low;
        int n;
        n = 0;
        cyc(0, 0, 7'h00, 1, ch, 0, 0);
        while (!last_fire && n < 50) begin
            cyc(0, 0, 7'h00, 1, ch, 0, 0);
            n++;
        end
        check("paste_accept", {31'b0, last_fire}, 32'd1);
        low = 0;
        idle();
        if (!last_pr) low++;
        cyc(0, 0, 7'h00, 0, 7'h00, 1, 0, rd_exp);
        if (!last_pr) low++;
        n = 0;
        while (n < 40) begin
            idle();
            if (last_pr) break;
            low++;
            n++;
        end
        check_ge("gap_cycles", low, gap_min);
        check("ready_again", {31'b0, last_pr}, 32'd1);
    endtask

    initial begin
        logic       pv_r;
        logic [6:0] pa_r;
        logic       r;
        logic       c;
        int         n;

        rst = 1'b1; ps2_valid = 0; ps2_ascii = 0; paste_valid = 0; paste_ascii = 0;
        cs = 0; address = 0;
        m_key = 0; m_rdy = 0; m_ovf = 0; m_gap = 0;

        // 1: reset state and single typed key
        cur_test = "t1";
        repeat (3) cyc(1, 0, 7'h00, 0, 7'h00, 0, 0);
        idle();
        check("rst_dout", {24'b0, dout}, 32'h00);
        check("rst_ovf", {31'b0, overflow}, 32'd0);
        check("rst_ready", {31'b0, last_pr}, 32'd1);
        cyc(0, 1, 7'h41, 0, 7'h00, 0, 0);
        idle();
        cyc(0, 0, 7'h00, 0, 7'h00, 1, 1, 'h80);
        cyc(0, 0, 7'h00, 0, 7'h00, 1, 0, 'hC1);
        cyc(0, 0, 7'h00, 0, 7'h00, 1, 1, 'h00);

        // 2: fill holding + FIFO, then overflow
        cur_test = "t2";
        for (int i = 0; i < 9; i++) cyc(0, 1, 7'(7'h41 + i), 0, 7'h00, 0, 0);
        idle();
        check("no_drop_ovf", {31'b0, overflow}, 32'd0);
        cyc(0, 0, 7'h00, 0, 7'h00, 1, 1, 'h80);
        cyc(0, 1, 7'h4A, 0, 7'h00, 0, 0);
        idle();
        check("drop_ovf", {31'b0, overflow}, 32'd1);
        cyc(0, 0, 7'h00, 0, 7'h00, 1, 1, 'hC0);
        idle();
        check("ovf_cleared", {31'b0, overflow}, 32'd0);
        cyc(0, 0, 7'h00, 0, 7'h00, 1, 1, 'h80);
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 7'h00, 0, 7'h00, 1, 0, 'hC1 + i);
            idle();
        end
        cyc(0, 0, 7'h00, 0, 7'h00, 1, 1, 'h00);

        // 3: paced paste of "HI\r"
        cur_test = "t3";
        paste_char(7'h48, PG, 'hC8);
        paste_char(7'h49, PG, 'hC9);
        paste_char(7'h0D, CG, 'h8D);

        // 4: typed strobe wins over a ready paste
        cur_test = "t4";
        cyc(0, 1, 7'h51, 1, 7'h50, 0, 0);
        check("strobe_blocks", {31'b0, last_pr}, 32'd0);
        cyc(0, 0, 7'h00, 1, 7'h50, 0, 0);
        cyc(0, 0, 7'h00, 1, 7'h50, 0, 0);
        check("held_blocks", {31'b0, last_pr}, 32'd0);
        cyc(0, 0, 7'h00, 1, 7'h50, 1, 0, 'hD1);
        cyc(0, 0, 7'h00, 1, 7'h50, 0, 0);
        check("paste_after_q", {31'b0, last_fire}, 32'd1);
        idle();
        cyc(0, 0, 7'h00, 0, 7'h00, 1, 0, 'hD0);

        // 5: read-clear vs pending load
        cur_test = "t5";
        cyc(0, 1, 7'h41, 0, 7'h00, 0, 0);
        cyc(0, 1, 7'h42, 0, 7'h00, 0, 0);
        cyc(0, 0, 7'h00, 0, 7'h00, 1, 0, 'hC1);
        cyc(0, 0, 7'h00, 0, 7'h00, 1, 1, 'h00);
        cyc(0, 0, 7'h00, 0, 7'h00, 1, 1, 'h80);
        cyc(0, 0, 7'h00, 0, 7'h00, 1, 0, 'hC2);

        // 6: mid-operation reset with queued chars and a running gap
        cur_test = "t6";
        n = 0;
        cyc(0, 0, 7'h00, 1, 7'h0D, 0, 0);
        while (!last_fire && n < 50) begin
            cyc(0, 0, 7'h00, 1, 7'h0D, 0, 0);
            n++;
        end
        check("cr_accept", {31'b0, last_fire}, 32'd1);
        cyc(0, 1, 7'h58, 0, 7'h00, 0, 0);
        cyc(0, 1, 7'h59, 0, 7'h00, 0, 0);
        cyc(0, 1, 7'h5A, 0, 7'h00, 0, 0);
        cyc(1, 0, 7'h00, 1, 7'h4B, 0, 0);
        check("ready_in_rst", {31'b0, last_pr}, 32'd0);
        idle();
        check("post_rst_dout", {24'b0, dout}, 32'h00);
        check("post_rst_ready", {31'b0, last_pr}, 32'd1);
        cyc(0, 0, 7'h00, 0, 7'h00, 1, 1, 'h00);
        cyc(0, 0, 7'h00, 0, 7'h00, 1, 0, 'h80);
        cyc(0, 0, 7'h00, 0, 7'h00, 1, 1, 'h00);

        // Randomized traffic against the model
        cur_test = "rand";
        pv_r = 1'b0;
        pa_r = 7'h00;
        for (int i = 0; i < 4000; i++) begin
            if (!pv_r && $urandom_range(0, 1) == 0) begin
                pv_r = 1'b1;
                pa_r = ($urandom_range(0, 4) == 0) ? 7'h0D : 7'($urandom_range(32, 95));
            end
            r = ($urandom_range(0, 399) == 0);
            c = !r && ($urandom_range(0, 2) == 0);
            cyc(r, ($urandom_range(0, 5) == 0), 7'($urandom_range(0, 127)),
                pv_r, pa_r, c, 1'($urandom_range(0, 1)));
            if (last_fire) pv_r = 1'b0;
        end
        repeat (3) idle();
        check("sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
